// File: rtl/gap_serializer.sv
// gap_serializer: per-channel pooling (average or max, optional abs) over a
// frame of INPUT_SIZE samples, then serial write of one pooled word per
// channel, channel 0 first, into a downstream FIFO write port.
//
// state | meaning
// ACCUM | accept samples per channel until every channel holds INPUT_SIZE
// FINAL | one cycle: scale/saturate accumulators into the result registers
// SEND  | write res[0..NUM_CHANNELS-1], stalling while full_i is high
module gap_serializer #(
  parameter int WORD_SIZE    = 16,
  parameter int N_SIZE       = 12,
  parameter int NUM_CHANNELS = 8,
  parameter int INPUT_SIZE   = 13,
  parameter int POOL_MODE    = 0,
  parameter int ABS_EN       = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_CHANNELS-1:0]         valid_i,
  output logic [NUM_CHANNELS-1:0]         ready_o,
  input  logic [NUM_CHANNELS*WORD_SIZE-1:0] data_i,
  output logic                            wen_o,
  input  logic                            full_i,
  output logic [WORD_SIZE-1:0]            data_o,
  output logic                            busy_o
);

  localparam int CNT_W     = $clog2(INPUT_SIZE + 1);
  localparam int ACC_W     = WORD_SIZE + $clog2(INPUT_SIZE) + 1;
  localparam int K_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int RECIP_W   = N_SIZE + 2;
  localparam int PROD_W    = ACC_W + RECIP_W + 1;
  // Rounded reciprocal of the frame length, Q(N_SIZE) unsigned.
  localparam int RECIP_INT = ((2 ** (N_SIZE + 1)) / INPUT_SIZE + 1) / 2;

  localparam logic [RECIP_W-1:0] RECIP    = RECIP_W'(RECIP_INT);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(INPUT_SIZE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(INPUT_SIZE - 1);
  localparam logic [K_W-1:0]     K_LAST   = K_W'(NUM_CHANNELS - 1);

  localparam logic signed [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic signed [PROD_W-1:0]    SAT_HI   = PROD_W'(WORD_MAX);
  localparam logic signed [PROD_W-1:0]    SAT_LO   = PROD_W'(WORD_MIN);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        [CNT_W-1:0]     cnt      [NUM_CHANNELS];
  logic signed [ACC_W-1:0]     acc      [NUM_CHANNELS];
  logic signed [WORD_SIZE-1:0] res      [NUM_CHANNELS];
  logic signed [WORD_SIZE-1:0] raw      [NUM_CHANNELS];
  logic signed [WORD_SIZE-1:0] samp     [NUM_CHANNELS];
  logic signed [ACC_W-1:0]     samp_ext [NUM_CHANNELS];
  logic signed [PROD_W-1:0]    prod     [NUM_CHANNELS];
  logic signed [PROD_W-1:0]    scaled   [NUM_CHANNELS];
  logic signed [WORD_SIZE-1:0] pool_res [NUM_CHANNELS];
  logic        [NUM_CHANNELS-1:0] take;
  logic        [NUM_CHANNELS-1:0] done_nxt;
  logic        [K_W-1:0]          k;

  // Sample conditioning: optional absolute value, most-negative clamps to max.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      raw[c]  = data_i[c*WORD_SIZE +: WORD_SIZE];
      samp[c] = raw[c];
      if ((ABS_EN != 0) && raw[c][WORD_SIZE-1]) begin
        samp[c] = (raw[c] == WORD_MIN) ? WORD_MAX : -raw[c];
      end
      samp_ext[c] = ACC_W'(samp[c]);
    end
  end

  // Handshake accept and "this channel is complete after this edge" flags.
  always_comb begin
    take     = '0;
    done_nxt = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      take[c]     = valid_i[c] & ready_o[c];
      done_nxt[c] = (cnt[c] == CNT_FULL) || (take[c] && (cnt[c] == CNT_LAST));
    end
  end

  // Pooled result per channel: scaled-and-saturated average, or the running max.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      prod[c]   = PROD_W'(acc[c]) * PROD_W'($signed({1'b0, RECIP}));
      scaled[c] = prod[c] >>> N_SIZE;
      if (POOL_MODE != 0) begin
        pool_res[c] = acc[c][WORD_SIZE-1:0];
      end else if (scaled[c] > SAT_HI) begin
        pool_res[c] = WORD_MAX;
      end else if (scaled[c] < SAT_LO) begin
        pool_res[c] = WORD_MIN;
      end else begin
        pool_res[c] = scaled[c][WORD_SIZE-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ACCUM;
    else         state <= state_nxt;
  end

  // Next-state logic; the last channel's final sample may trigger FINAL directly.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (&done_nxt) state_nxt = FINAL;
      FINAL:   state_nxt = SEND;
      SEND:    if (wen_o && (k == K_LAST)) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Outputs decoded from state; wen_o follows full_i combinationally in SEND.
  always_comb begin
    ready_o = '0;
    wen_o   = 1'b0;
    busy_o  = 1'b0;
    data_o  = '0;
    case (state)
      ACCUM: begin
        for (int c = 0; c < NUM_CHANNELS; c++) ready_o[c] = (cnt[c] != CNT_FULL);
      end
      FINAL: busy_o = 1'b1;
      SEND: begin
        busy_o = 1'b1;
        wen_o  = ~full_i;
        data_o = res[k];
      end
      default: ;
    endcase
  end

  // Datapath: accumulate in ACCUM, latch results in FINAL, step/clear in SEND.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      k <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt[c] <= '0;
        acc[c] <= '0;
        res[c] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (take[c]) begin
              cnt[c] <= cnt[c] + CNT_W'(1);
              if (POOL_MODE != 0) begin
                if ((cnt[c] == '0) || (samp_ext[c] > acc[c])) acc[c] <= samp_ext[c];
              end else begin
                acc[c] <= acc[c] + samp_ext[c];
              end
            end
          end
        end
        FINAL: begin
          k <= '0;
          for (int c = 0; c < NUM_CHANNELS; c++) res[c] <= pool_res[c];
        end
        SEND: begin
          if (wen_o) begin
            if (k == K_LAST) begin
              k <= '0;
              for (int c = 0; c < NUM_CHANNELS; c++) begin
                cnt[c] <= '0;
                acc[c] <= '0;
              end
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gap_serializer.sv
// Directed bench for gap_serializer: an average-mode and a max-mode instance
// share every input, so each frame is checked under both pooling modes.
module tb_gap_serializer;

  logic        clk_i;
  logic        reset_i;
  logic [2:0]  valid_i;
  logic [47:0] data_i;
  logic        full_i;
  logic [2:0]  ready_o, ready_m;
  logic        wen_o, wen_m;
  logic [15:0] data_o, data_m;
  logic        busy_o, busy_m;

  typedef struct { logic [15:0] d; int cyc; } wr_t;
  typedef struct { int ch; int cyc; } acc_t;

  wr_t  wr_q[$];
  wr_t  wrm_q[$];
  acc_t acc_q[$];
  int   cyc_n = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic [15:0] smp [3][8];
  int          start_dly [3];

  gap_serializer #(.WORD_SIZE(16), .N_SIZE(12), .NUM_CHANNELS(3), .INPUT_SIZE(4),
                   .POOL_MODE(0), .ABS_EN(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .wen_o(wen_o), .full_i(full_i), .data_o(data_o), .busy_o(busy_o));

  gap_serializer #(.WORD_SIZE(16), .N_SIZE(12), .NUM_CHANNELS(3), .INPUT_SIZE(4),
                   .POOL_MODE(1), .ABS_EN(1)) dut_max (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_m),
    .data_i(data_i), .wen_o(wen_m), .full_i(full_i), .data_o(data_m), .busy_o(busy_m));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  // Record writes and accepted samples mid-cycle.
  always @(negedge clk_i) begin
    wr_t  w;
    acc_t a;
    if (wen_o) begin w.d = data_o; w.cyc = cyc_n; wr_q.push_back(w); end
    if (wen_m) begin w.d = data_m; w.cyc = cyc_n; wrm_q.push_back(w); end
    for (int c = 0; c < 3; c++) begin
      if (valid_i[c] && ready_o[c]) begin a.ch = c; a.cyc = cyc_n; acc_q.push_back(a); end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_q.delete();
    wrm_q.delete();
    acc_q.delete();
  endtask

  task automatic load_basic(input int base);
    for (int i = 0; i < 4; i++) begin
      smp[0][base+i] = 16'h1000;
      smp[1][base+i] = 16'hF800;
      smp[2][base+i] = 16'(i * 4096);
    end
  endtask

  task automatic load_frame2(input int base);
    for (int i = 0; i < 4; i++) begin
      smp[0][base+i] = 16'h2000;
      smp[1][base+i] = 16'h0400;
      smp[2][base+i] = 16'hF000;
    end
  endtask

  // Offers nsamp samples per channel; starts and ends at posedge+1.
  task automatic drive_frame(input int nsamp, input int bound, output bit ok);
    int idx [3];
    int n;
    for (int c = 0; c < 3; c++) idx[c] = 0;
    n = 0;
    while ((idx[0] < nsamp || idx[1] < nsamp || idx[2] < nsamp) && n < bound) begin
      for (int c = 0; c < 3; c++) begin
        if (idx[c] < nsamp && n >= start_dly[c]) begin
          valid_i[c] = 1'b1;
          data_i[c*16 +: 16] = smp[c][idx[c]];
        end else begin
          valid_i[c] = 1'b0;
          data_i[c*16 +: 16] = 16'h0000;
        end
      end
      #1;
      for (int c = 0; c < 3; c++) if (valid_i[c] && ready_o[c]) idx[c]++;
      @(posedge clk_i); #1;
      n++;
    end
    valid_i = 3'b000;
    ok = (idx[0] >= nsamp) && (idx[1] >= nsamp) && (idx[2] >= nsamp);
  endtask

  task automatic wait_writes(input int count);
    int n;
    n = 0;
    while (wr_q.size() < count && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    repeat (3) begin @(posedge clk_i); #1; end
  endtask

  task automatic test_reset();
    #3;
    compared++; if (ready_o !== 3'b111) begin mismatched++; $display("FAIL reset_ready: got %b expected 111", ready_o); end
    compared++; if (wen_o !== 1'b0) begin mismatched++; $display("FAIL reset_wen: got %b expected 0", wen_o); end
    compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    compared++; if (data_o !== 16'h0000) begin mismatched++; $display("FAIL reset_data: got %h expected 0000", data_o); end
    compared++; if ({ready_m, wen_m, busy_m} !== 5'b11100) begin mismatched++; $display("FAIL reset_max_inst: got %b expected 11100", {ready_m, wen_m, busy_m}); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic_avg();
    bit ok;
    int last;
    logic [15:0] got;
    logic [15:0] exp_a [3];
    logic [15:0] exp_m [3];
    exp_a = '{16'h1000, 16'h0800, 16'h1800};
    exp_m = '{16'h1000, 16'h0800, 16'h3000};
    clear_logs();
    load_basic(0);
    start_dly = '{0, 0, 0};
    drive_frame(4, 40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL basic_drive: got incomplete frame expected all accepted"); end
    wait_writes(3);
    compared++; if (wr_q.size() !== 3) begin mismatched++; $display("FAIL basic_count: got %0d writes expected 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (wr_q.size() > i) ? wr_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_a[i]) begin mismatched++; $display("FAIL basic_avg_word%0d: got %h expected %h", i, got, exp_a[i]); end
      got = (wrm_q.size() > i) ? wrm_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_m[i]) begin mismatched++; $display("FAIL basic_max_word%0d: got %h expected %h", i, got, exp_m[i]); end
    end
    last = -100;
    foreach (acc_q[i]) if (acc_q[i].cyc > last) last = acc_q[i].cyc;
    compared++;
    if (wr_q.size() == 0 || wr_q[0].cyc !== last + 2) begin
      mismatched++;
      $display("FAIL basic_latency: got write cycle %0d expected %0d", (wr_q.size() > 0) ? wr_q[0].cyc : -1, last + 2);
    end
    #1;
    compared++; if (ready_o !== 3'b111) begin mismatched++; $display("FAIL basic_ready_after: got %b expected 111", ready_o); end
    compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL basic_busy_after: got %b expected 0", busy_o); end
  endtask

  task automatic test_skewed();
    bit ok;
    int bad01, bad2;
    logic [15:0] got;
    logic [15:0] exp_a [3];
    exp_a = '{16'h1000, 16'h0800, 16'h1800};
    clear_logs();
    load_basic(0);
    start_dly = '{0, 0, 10};
    bad01 = 0;
    bad2 = 0;
    fork
      drive_frame(4, 60, ok);
      begin
        repeat (5) @(posedge clk_i);
        #2;
        repeat (8) begin
          if (ready_o[1:0] !== 2'b00) bad01++;
          if (ready_o[2] !== 1'b1) bad2++;
          @(posedge clk_i); #2;
        end
      end
    join
    compared++; if (!ok) begin mismatched++; $display("FAIL skew_drive: got incomplete frame expected all accepted"); end
    compared++; if (bad01 !== 0) begin mismatched++; $display("FAIL skew_ready01_low: got %0d cycles high expected 0", bad01); end
    compared++; if (bad2 !== 0) begin mismatched++; $display("FAIL skew_ready2_high: got %0d cycles low expected 0", bad2); end
    wait_writes(3);
    compared++; if (wr_q.size() !== 3) begin mismatched++; $display("FAIL skew_count: got %0d writes expected 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (wr_q.size() > i) ? wr_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_a[i]) begin mismatched++; $display("FAIL skew_word%0d: got %h expected %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_max_abs_sat();
    bit ok;
    logic [15:0] got;
    logic [15:0] exp_m [3];
    logic [15:0] exp_a [3];
    exp_m = '{16'h0010, 16'h7FFF, 16'h0003};
    exp_a = '{16'h0006, 16'h7FFF, 16'h0003};
    clear_logs();
    smp[0][0] = 16'h0001; smp[0][1] = 16'h0005; smp[0][2] = 16'hFFF0; smp[0][3] = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      smp[1][i] = 16'h8000;
      smp[2][i] = 16'h0003;
    end
    start_dly = '{0, 0, 0};
    drive_frame(4, 40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL max_drive: got incomplete frame expected all accepted"); end
    wait_writes(3);
    for (int i = 0; i < 3; i++) begin
      got = (wrm_q.size() > i) ? wrm_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_m[i]) begin mismatched++; $display("FAIL max_word%0d: got %h expected %h", i, got, exp_m[i]); end
      got = (wr_q.size() > i) ? wr_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_a[i]) begin mismatched++; $display("FAIL max_avg_word%0d: got %h expected %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n, bad_wen, bad_data, bad_busy;
    logic [15:0] got;
    logic [15:0] exp_a [3];
    exp_a = '{16'h1000, 16'h0800, 16'h1800};
    clear_logs();
    load_basic(0);
    start_dly = '{0, 0, 0};
    drive_frame(4, 40, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL bp_drive: got incomplete frame expected all accepted"); end
    n = 0;
    #1;
    while (!wen_o && n < 10) begin @(posedge clk_i); #2; n++; end
    compared++; if (wen_o !== 1'b1) begin mismatched++; $display("FAIL bp_first_write: got wen %b expected 1", wen_o); end
    @(posedge clk_i); #1;
    full_i = 1'b1;
    bad_wen = 0; bad_data = 0; bad_busy = 0;
    repeat (5) begin
      #1;
      if (wen_o !== 1'b0) bad_wen++;
      if (data_o !== 16'h0800) bad_data++;
      if (busy_o !== 1'b1) bad_busy++;
      @(posedge clk_i); #1;
    end
    full_i = 1'b0;
    compared++; if (bad_wen !== 0) begin mismatched++; $display("FAIL bp_wen_low: got %0d stall cycles with wen expected 0", bad_wen); end
    compared++; if (bad_data !== 0) begin mismatched++; $display("FAIL bp_data_hold: got %0d cycles not 0800 expected 0", bad_data); end
    compared++; if (bad_busy !== 0) begin mismatched++; $display("FAIL bp_busy: got %0d cycles not busy expected 0", bad_busy); end
    wait_writes(3);
    compared++; if (wr_q.size() !== 3) begin mismatched++; $display("FAIL bp_count: got %0d writes expected 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (wr_q.size() > i) ? wr_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_a[i]) begin mismatched++; $display("FAIL bp_word%0d: got %h expected %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic [15:0] got;
    logic [15:0] exp_a [3];
    exp_a = '{16'h1000, 16'h0800, 16'h1800};
    load_basic(0);
    start_dly = '{0, 0, 0};
    drive_frame(2, 20, ok);
    #2;
    reset_i = 1'b1;
    #1;
    compared++; if (ready_o !== 3'b111) begin mismatched++; $display("FAIL rst_accum_ready: got %b expected 111", ready_o); end
    compared++; if (wen_o !== 1'b0) begin mismatched++; $display("FAIL rst_accum_wen: got %b expected 0", wen_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    clear_logs();
    drive_frame(4, 40, ok);
    wait_writes(3);
    for (int i = 0; i < 3; i++) begin
      got = (wr_q.size() > i) ? wr_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_a[i]) begin mismatched++; $display("FAIL rst_accum_word%0d: got %h expected %h", i, got, exp_a[i]); end
    end
    drive_frame(4, 40, ok);
    n = 0;
    #1;
    while (!wen_o && n < 10) begin @(posedge clk_i); #2; n++; end
    compared++; if (wen_o !== 1'b1) begin mismatched++; $display("FAIL rst_send_reached: got wen %b expected 1", wen_o); end
    #1;
    reset_i = 1'b1;
    #1;
    compared++; if (wen_o !== 1'b0) begin mismatched++; $display("FAIL rst_send_wen: got %b expected 0", wen_o); end
    compared++; if (ready_o !== 3'b111) begin mismatched++; $display("FAIL rst_send_ready: got %b expected 111", ready_o); end
    compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL rst_send_busy: got %b expected 0", busy_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    clear_logs();
    drive_frame(4, 40, ok);
    wait_writes(3);
    compared++; if (wr_q.size() !== 3) begin mismatched++; $display("FAIL rst_send_count: got %0d writes expected 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (wr_q.size() > i) ? wr_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_a[i]) begin mismatched++; $display("FAIL rst_send_word%0d: got %h expected %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int seen [3];
    int fifth [3];
    int third_wr;
    logic [15:0] got;
    logic [15:0] exp_a [6];
    exp_a = '{16'h1000, 16'h0800, 16'h1800, 16'h2000, 16'h0400, 16'h1000};
    clear_logs();
    load_basic(0);
    load_frame2(4);
    start_dly = '{0, 0, 0};
    drive_frame(8, 80, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_drive: got incomplete frames expected all accepted"); end
    wait_writes(6);
    compared++; if (wr_q.size() !== 6) begin mismatched++; $display("FAIL b2b_count: got %0d writes expected 6", wr_q.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (wr_q.size() > i) ? wr_q[i].d : 16'hxxxx;
      compared++; if (got !== exp_a[i]) begin mismatched++; $display("FAIL b2b_word%0d: got %h expected %h", i, got, exp_a[i]); end
    end
    for (int c = 0; c < 3; c++) begin seen[c] = 0; fifth[c] = -1; end
    foreach (acc_q[i]) begin
      if (seen[acc_q[i].ch] == 4) fifth[acc_q[i].ch] = acc_q[i].cyc;
      seen[acc_q[i].ch]++;
    end
    third_wr = (wr_q.size() > 2) ? wr_q[2].cyc : -10;
    compared++; if (fifth[0] !== third_wr + 1) begin mismatched++; $display("FAIL b2b_ch0_resume: got accept cycle %0d expected %0d", fifth[0], third_wr + 1); end
    compared++; if (fifth[2] !== third_wr + 1) begin mismatched++; $display("FAIL b2b_ch2_resume: got accept cycle %0d expected %0d", fifth[2], third_wr + 1); end
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 3'b000;
    data_i  = '0;
    full_i  = 1'b0;
    test_reset();
    test_basic_avg();
    test_skewed();
    test_max_abs_sat();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gap_serializer.md
Name: gap_serializer

Overview:
- Multi-channel pooling and serialising stage for the feature-extractor front end.
- Takes NUM_CHANNELS independent per-kernel sample streams, each with a valid/ready handshake.
- Optionally applies absolute value, then pools each channel over INPUT_SIZE samples, using either global average or global max.
- Sends the NUM_CHANNELS pooled words, one per write, channel 0 first, into a FIFO-style write port that feeds the next fc_layer's input FIFO.

Parameters:
- WORD_SIZE, 16, signed fixed-point word width.
- N_SIZE, 12, fractional bits (WORD_SIZE-INT_BITS).
- NUM_CHANNELS, 8, number of parallel input channels (≥1).
- INPUT_SIZE, 13, samples per channel per frame (≥1).
- POOL_MODE, 0, 0 = average, 1 = max.
- ABS_EN, 1, 1 = take absolute value of each sample before pooling.

Ports:
- clk_i, input, 1, clock, rising edge.
- reset_i, input, 1, asynchronous active-high reset.
- valid_i, input, NUM_CHANNELS, per-channel sample valid.
- ready_o, output, NUM_CHANNELS, per-channel ready; a sample transfers when valid_i[c] & ready_o[c].
- data_i, input, NUM_CHANNELS×WORD_SIZE, packed per-channel signed samples.
- wen_o, output, 1, write enable to downstream FIFO; one word transferred per cycle it is high.
- full_i, input, 1, downstream FIFO full.
- data_o, output, WORD_SIZE, pooled word; meaningful only while wen_o is high.
- busy_o, output, 1, high in FINAL or SEND states.

Behaviour:
- Reset (async, any time, including mid-frame or mid-send): state=ACCUM; all accumulators, counters and result registers cleared; ready_o=all 1; wen_o=0; data_o=0; busy_o=0. The partial frame is discarded.
- States: ACCUM → FINAL → SEND → ACCUM.
- ACCUM, per channel c (channels are independent):
  - Sample s' = ABS_EN ? |s| : s. |−2^(WORD_SIZE−1)| saturates to 2^(WORD_SIZE−1)−1.
  - Average mode: acc[c] += s'. acc width = WORD_SIZE+$clog2(INPUT_SIZE)+1, signed, no overflow possible.
  - Max mode: acc[c] = (count==0) ? s' : max(acc[c], s'), signed compare.
  - cnt[c] increments per accepted sample. ready_o[c] drops the cycle after cnt[c] reaches INPUT_SIZE and stays low until the next ACCUM entry.
  - Extra valid_i on a completed channel is ignored and not consumed.
- ACCUM→FINAL: the cycle after all cnt[c]==INPUT_SIZE.
  - The transition may coincide with the last channel's final sample; that sample is included.
- FINAL (exactly 1 cycle): res[c] computed and registered for all channels.
  - Average: res = sat_WORD((acc × RECIP) >>> N_SIZE), where RECIP = round(2^N_SIZE / INPUT_SIZE), fixed at elaboration, width N_SIZE+2 unsigned.
  - The shift is arithmetic (floor). Saturation goes to [−2^(WORD_SIZE−1), 2^(WORD_SIZE−1)−1].
  - Max: res = acc.
  - ready_o all 0.
- SEND: index k from 0 to NUM_CHANNELS−1.
  - wen_o = ~full_i combinationally; data_o = res[k].
  - k advances on each cycle with wen_o=1.
  - full_i high stalls indefinitely with no word lost or duplicated.
  - After the write of k=NUM_CHANNELS−1, the next state is ACCUM with all acc and cnt cleared and ready_o all 1.
  - Minimum frame-to-frame gap: 1 + NUM_CHANNELS cycles with no backpressure.
- Input latency: first word is written 2 cycles after the last sample of the last channel is accepted (when full_i is low).
- Samples are never accepted outside ACCUM, so next-frame data is held off by the handshake rather than dropped.

Test Plan:
Configuration for all scenarios: WORD_SIZE=16, N_SIZE=12, NUM_CHANNELS=3, INPUT_SIZE=4, POOL_MODE=0, ABS_EN=1 unless stated.
1. Basic average:
   - Stimulus: ch0 4×0x1000, ch1 4×0xF800 (−0.5), ch2 0x0000,0x1000,0x2000,0x3000, all with valid_i constantly high.
   - Required: writes 0x1000, 0x0800, 0x1800 in that order; first wen_o 2 cycles after the last accept.
2. Skewed channels:
   - Stimulus: ch2 finishes 10 cycles after ch0/ch1.
   - Required: ready_o[0] and ready_o[1] stay low meanwhile; results are identical to scenario 1; exactly 3 writes.
3. Max mode and abs saturation:
   - Stimulus: POOL_MODE=1; ch0 0x0001,0x0005,0xFFF0,0x0002; ch1 4×0x8000.
   - Required: ch0 result 0x0010; ch1 result 0x7FFF.
4. Backpressure:
   - Stimulus: full_i high for 5 cycles at k=1 of scenario 1.
   - Required: wen_o=0 during the stall; data_o holds 0x0800; sequence resumes 0x0800, 0x1800 with no duplicate writes; busy_o stays high throughout.
5. Reset mid-operation:
   - Stimulus: assert reset_i asynchronously after 2 samples per channel, and again during SEND.
   - Required: wen_o=0 and ready_o=3'b111 immediately after reset; the next full frame produces the scenario-1 values, unaffected by the old data.
6. Back-to-back frames:
   - Stimulus: valid_i held high through two frames.
   - Required: second-frame samples are only accepted after the third write; 6 writes total in the correct order.
